// File: rtl/ram_bus_master.sv
// Single-beat initiator for the shared-bus RAM (bus/addr/cs/wa/oa).
// Converts valid/ready requests into RAM cycles, with a turnaround cycle after each access.
module ram_bus_master #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 4,
  parameter int RD_WAIT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              wr_done,
  inout  wire  [DATA_W-1:0] bus,
  output logic [ADDR_W-1:0] addr,
  output logic              cs,
  output logic              wa,
  output logic              oa
);

  localparam int              CNT_W    = $clog2(RD_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_WAIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    TURN  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] wdata_p0;
  logic              write_p0;
  logic              bus_en;
  logic              accept;
  logic              rd_last;

  assign accept  = req_valid && (state == IDLE);
  assign rd_last = (state == READ) && (cnt == CNT_LAST);

  // Request capture stage: address, direction and write data latched on accept
  always_ff @(posedge clk) begin
    if (rst) begin
      addr     <= '0;
      write_p0 <= 1'b0;
    end else if (accept) begin
      addr     <= req_addr;
      write_p0 <= req_write;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      wdata_p0 <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Read wait counter restarts on every READ entry, so no explicit clear is needed at IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if ((state == READ) && !rd_last) begin
      cnt <= cnt + 1'b1;
    end else begin
      cnt <= '0;
    end
  end

  // Response stage: bus copied verbatim at the edge closing the last read wait cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_rdata <= '0;
    end else if (rd_last) begin
      rsp_rdata <= bus;
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    cs        = 1'b0;
    wa        = 1'b0;
    oa        = 1'b0;
    bus_en    = 1'b0;
    wr_done   = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_nxt = req_write ? WRITE : READ;
        end
      end
      WRITE: begin
        cs        = 1'b1;
        wa        = 1'b1;
        bus_en    = 1'b1;
        state_nxt = TURN;
      end
      READ: begin
        cs = 1'b1;
        oa = 1'b1;
        if (cnt == CNT_LAST) begin
          state_nxt = TURN;
        end
      end
      TURN: begin
        wr_done   = write_p0;
        rsp_valid = !write_p0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus = bus_en ? wdata_p0 : {DATA_W{1'bz}};

endmodule
